// File: rtl/axil_pkg.sv
// +--------------------------------------------------------------------+
// | axil_pkg : shared constants and FSM encodings for the AXI-Lite     |
// |            register slave.                  Revision: 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

package axil_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/axil_regfile.sv
// +--------------------------------------------------------------------+
// | axil_regfile : NUM_REGS x 32-bit storage, byte-strobed write port, |
// |                one combinational read port.     Revision: 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module axil_regfile
  import axil_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wstrb[b]) begin
          regs_d[waddr][b*8 +: 8] = wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle commit is not visible.
  assign rdata = regs_q[raddr];

endmodule

`default_nettype wire

// File: rtl/axil_slave_regs.sv
// +--------------------------------------------------------------------+
// | axil_slave_regs : AXI4-Lite slave with independent write/read FSMs |
// |   over a 32-bit register bank. Option macro: AXIL_SLV_DECERR_EN.   |
// |                                                 Revision: 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module axil_slave_regs
  import axil_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] OOR_RESP = RESP_DECERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr >> 2) < ADDR_W'(NUM_REGS);
  endfunction

  logic                ready_en_q, ready_en_d;
  wr_state_e           wr_state_q, wr_state_d;
  logic                aw_have_q, aw_have_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic                w_have_q, w_have_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  rd_state_e           rd_state_q, rd_state_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic                wr_commit;
  logic [DATA_W-1:0]   rf_rdata;

  // Readies derive only from registered state; ready_en_q holds them low in reset.
  assign awready = ready_en_q && (wr_state_q == WR_IDLE) && !aw_have_q;
  assign wready  = ready_en_q && (wr_state_q == WR_IDLE) && !w_have_q;
  assign arready = ready_en_q && (rd_state_q == RD_IDLE);

  assign wr_commit = (wr_state_q == WR_IDLE) && aw_have_q && w_have_q && in_range(awaddr_q);

  axil_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (wr_commit),
    .waddr (awaddr_q[IDX_W+1:2]),
    .wdata (wdata_q),
    .wstrb (wstrb_q),
    .raddr (araddr[IDX_W+1:2]),
    .rdata (rf_rdata)
  );

  always_comb begin
    ready_en_d = 1'b1;
    wr_state_d = wr_state_q;
    aw_have_d  = aw_have_q;
    awaddr_d   = awaddr_q;
    w_have_d   = w_have_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (aw_have_q && w_have_q) begin
          bvalid_d   = 1'b1;
          bresp_d    = in_range(awaddr_q) ? RESP_OKAY : OOR_RESP;
          wr_state_d = WR_RESP;
        end else begin
          if (awvalid && awready) begin
            aw_have_d = 1'b1;
            awaddr_d  = awaddr;
          end
          if (wvalid && wready) begin
            w_have_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
          end
        end
      end
      WR_RESP: begin
        if (bready) begin
          bvalid_d   = 1'b0;
          aw_have_d  = 1'b0;
          w_have_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (arvalid && arready) begin
          rvalid_d   = 1'b1;
          rdata_d    = in_range(araddr) ? rf_rdata : '0;
          rresp_d    = in_range(araddr) ? RESP_OKAY : OOR_RESP;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_en_q <= 1'b0;
      wr_state_q <= WR_IDLE;
      aw_have_q  <= 1'b0;
      awaddr_q   <= '0;
      w_have_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rd_state_q <= RD_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      ready_en_q <= ready_en_d;
      wr_state_q <= wr_state_d;
      aw_have_q  <= aw_have_d;
      awaddr_q   <= awaddr_d;
      w_have_q   <= w_have_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_slave_regs.sv
// +--------------------------------------------------------------------+
// | tb_axil_slave_regs : self-checking bench for axil_slave_regs,      |
// |   honours AXIL_SLV_DECERR_EN.                   Revision: 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_axil_slave_regs;

  localparam int ADDR_W   = 32;
  localparam int NUM_REGS = 16;

`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] OOR = 2'b11;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] awaddr = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [ADDR_W-1:0] araddr = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [NUM_REGS];

  always #5 clk = ~clk;

  axil_slave_regs #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  function automatic bit in_rng(input logic [31:0] a);
    return (a / 4) < NUM_REGS;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_rng(a) ? 2'b00 : OOR;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return in_rng(a) ? model[a / 4] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a / 4][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
  endtask

  // Handshakes AW and W with independent start delays, then checks response timing.
  task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      if (aw_done) begin
        checks++;
        if (awready !== 1'b0) begin errors++; $display("FAIL awready_after_aw: got %b want 0", awready); end
      end
      if (w_done) begin
        checks++;
        if (wready !== 1'b0) begin errors++; $display("FAIL wready_after_w: got %b want 0", wready); end
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); @(negedge clk);
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (!(aw_done && w_done)) begin
      errors++; $display("FAIL wr_handshake_timeout: aw=%0d w=%0d want both 1", aw_done, w_done);
      return;
    end
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_early: got %b want 0", bvalid); end
    @(posedge clk); @(negedge clk);
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_latency: got %b want 1", bvalid); end
    checks++;
    if (bresp !== exp_resp(a)) begin errors++; $display("FAIL bresp @%h: got %b want %b", a, bresp, exp_resp(a)); end
    model_write(a, d, s);
  endtask

  task automatic wr_finish();
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_clear: got %b want 0", bvalid); end
  endtask

  task automatic rd_check(input logic [31:0] a);
    bit hs;
    int cyc;
    hs = 0; cyc = 0;
    araddr = a; rready = 1'b0;
    while (!hs && cyc < 40) begin
      arvalid = 1'b1;
      hs = arready;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    arvalid = 1'b0;
    checks++;
    if (!hs) begin errors++; $display("FAIL rd_handshake_timeout: got 0 want 1"); return; end
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("FAIL rvalid_latency: got %b want 1", rvalid); end
    checks++;
    if (rdata !== exp_rd(a)) begin errors++; $display("FAIL rdata @%h: got %h want %h", a, rdata, exp_rd(a)); end
    checks++;
    if (rresp !== exp_resp(a)) begin errors++; $display("FAIL rresp @%h: got %b want %b", a, rresp, exp_resp(a)); end
    rready = 1'b1;
    @(posedge clk); @(negedge clk);
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_clear: got %b want 0", rvalid); end
  endtask

  task automatic test_reset();
    model_clear();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL ready_in_reset: got %b want 000", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid, bresp, rresp} !== 6'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL outputs_in_reset: got %b/%h want 0/0", {bvalid, rvalid, bresp, rresp}, rdata);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL ready_after_reset: got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic();
    wr_issue(32'h10, 32'hCEEB2006, 4'hF, 0, 0);
    wr_finish();
    rd_check(32'h10);
  endtask

  task automatic test_strobe();
    wr_issue(32'h10, 32'hFFFFFFFF, 4'b0011, 0, 0);
    wr_finish();
    checks++;
    if (model[4] !== 32'hCEEBFFFF) begin errors++; $display("FAIL strobe_model: got %h want cee bffff", model[4]); end
    rd_check(32'h10);
  endtask

  task automatic test_w_first();
    wr_issue(32'h04, 32'h12345678, 4'hF, 3, 0);
    wr_finish();
    rd_check(32'h04);
  endtask

  task automatic test_out_of_range();
    wr_issue(32'h40, 32'hDEADBEEF, 4'hF, 0, 0);
    wr_finish();
    rd_check(32'h40);
    wr_issue(32'h44, 32'h55AA55AA, 4'h0, 1, 0);
    wr_finish();
    for (int i = 0; i < NUM_REGS; i++) rd_check(32'(i * 4));
  endtask

  task automatic test_backpressure();
    logic [1:0] br0;
    wr_issue(32'h10, 32'h0BADF00D, 4'hF, 0, 0);
    br0 = bresp;
    bready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bvalid !== 1'b1 || bresp !== br0) begin
        errors++; $display("FAIL bp_hold: got %b/%b want 1/%b", bvalid, bresp, br0);
      end
      checks++;
      if ({awready, wready} !== 2'b00) begin
        errors++; $display("FAIL bp_ready: got %b want 00", {awready, wready});
      end
      if (c == 0) begin
        araddr = 32'h10; arvalid = 1'b1; rready = 1'b1;
        checks++;
        if (arready !== 1'b1) begin errors++; $display("FAIL bp_arready: got %b want 1", arready); end
      end else begin
        arvalid = 1'b0;
      end
      if (c == 1) begin
        checks++;
        if (rvalid !== 1'b1 || rdata !== model[4]) begin
          errors++; $display("FAIL bp_read: got %b/%h want 1/%h", rvalid, rdata, model[4]);
        end
      end
      if (c == 2) begin
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL bp_read_done: got %b want 0", rvalid); end
      end
      @(posedge clk); @(negedge clk);
    end
    arvalid = 1'b0; rready = 1'b0;
    wr_finish();
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0]  s;
    for (int n = 0; n < 40; n++) begin
      a = (32'($urandom_range(0, 19)) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        wr_issue(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        wr_finish();
      end else begin
        rd_check(a);
      end
    end
  endtask

  task automatic test_reset_mid();
    wr_issue(32'h10, 32'hA5A5A5A5, 4'hF, 0, 0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_mid_bvalid: got %b want 0", bvalid); end
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_ready: got %b want 000", {awready, wready, arready});
    end
    reset = 1'b1;
    model_clear();
    @(posedge clk); @(negedge clk);
    rd_check(32'h10);
    wr_issue(32'h08, 32'h87654321, 4'hF, 0, 2);
    wr_finish();
    rd_check(32'h08);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_w_first();
    test_out_of_range();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
